// File: rtl/rggen_apb_reg_adapter_if.sv
// APB slave-side bus bundle for the register adapter.
interface rggen_apb_reg_adapter_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     psel;
  logic                     penable;
  logic                     pwrite;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [BUS_WIDTH-1:0]     pwdata;
  logic [BUS_WIDTH/8-1:0]   pstrb;
  logic                     pready;
  logic [BUS_WIDTH-1:0]     prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/rggen_apb_reg_adapter.sv
// APB to register-file access adapter (setup / one or more busy cycles / response).
// Optional busy timeout enabled by defining RGGEN_APB_REG_ADAPTER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for an APB setup phase
// BUSY    | register access in progress, o_reg_valid high
// RESP    | one-cycle pready pulse with registered response
module rggen_apb_reg_adapter #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  rggen_apb_reg_adapter_if.slave    apb_if,
  output logic                      o_reg_valid,
  output logic [ADDRESS_WIDTH-1:0]  o_reg_address,
  output logic [BUS_WIDTH-1:0]      o_reg_write_data,
  output logic [BUS_WIDTH-1:0]      o_reg_write_mask,
  output logic [BUS_WIDTH-1:0]      o_reg_read_mask,
  input  logic                      i_reg_ready,
  input  logic                      i_reg_error,
  input  logic [BUS_WIDTH-1:0]      i_reg_read_data
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int BYTES = BUS_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = {ADDRESS_WIDTH{1'b1}} << LSB;

  logic [1:0]               state_q;
  logic [1:0]               state_d;
  logic                     setup;
  logic                     busy;
  logic                     timeout;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     write_q;
  logic [BUS_WIDTH-1:0]     wdata_q;
  logic [BYTES-1:0]         strb_q;
  logic [BUS_WIDTH-1:0]     prdata_q;
  logic                     pslverr_q;

  assign setup = apb_if.psel & ~apb_if.penable;
  assign busy  = (state_q == ST_BUSY);

`ifdef RGGEN_APB_REG_ADAPTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] busy_cnt_q;

  // Counter sits at zero outside BUSY, so it is clear on every BUSY entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_cnt_q <= '0;
    end else if (!busy) begin
      busy_cnt_q <= '0;
    end else if (!timeout) begin
      busy_cnt_q <= busy_cnt_q + 1'b1;
    end
  end

  assign timeout = busy && !i_reg_ready && (busy_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
  assign timeout               = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (setup) state_d = ST_BUSY;
      ST_BUSY: if (i_reg_ready || timeout) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if ((state_q == ST_IDLE) && setup) begin
      addr_q  <= apb_if.paddr;
      write_q <= apb_if.pwrite;
      wdata_q <= apb_if.pwdata;
      strb_q  <= apb_if.pstrb;
    end
  end

  // Normal completion wins over a timeout landing on the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else if (busy && i_reg_ready) begin
      prdata_q  <= write_q ? '0 : i_reg_read_data;
      pslverr_q <= i_reg_error;
    end else if (timeout) begin
      prdata_q  <= '0;
      pslverr_q <= 1'b1;
    end
  end

  always_comb begin
    o_reg_write_mask = '0;
    o_reg_read_mask  = '0;
    if (busy) begin
      if (write_q) begin
        for (int k = 0; k < BYTES; k++) begin
          o_reg_write_mask[8*k +: 8] = {8{strb_q[k]}};
        end
      end else begin
        o_reg_read_mask = '1;
      end
    end
  end

  assign o_reg_valid      = busy;
  assign o_reg_address    = addr_q & ADDR_MASK;
  assign o_reg_write_data = wdata_q;

  assign apb_if.pready  = (state_q == ST_RESP);
  assign apb_if.prdata  = prdata_q;
  assign apb_if.pslverr = pslverr_q;
endmodule

// File: tb/tb_rggen_apb_reg_adapter.sv
// Directed and random APB transfers against a transaction-level model of the adapter.
module tb_rggen_apb_reg_adapter;
  localparam int AW = 16;
  localparam int BW = 32;
  localparam int NB = BW / 8;
  localparam int TO = 8;
`ifdef RGGEN_APB_REG_ADAPTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          reg_valid;
  logic [AW-1:0] reg_address;
  logic [BW-1:0] reg_write_data;
  logic [BW-1:0] reg_write_mask;
  logic [BW-1:0] reg_read_mask;
  logic          reg_ready;
  logic          reg_error;
  logic [BW-1:0] reg_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] exp_prdata;
  logic          exp_pslverr;

  always #5 clk = ~clk;

  rggen_apb_reg_adapter_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) apb_if ();

  rggen_apb_reg_adapter #(
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .apb_if           (apb_if),
    .o_reg_valid      (reg_valid),
    .o_reg_address    (reg_address),
    .o_reg_write_data (reg_write_data),
    .o_reg_write_mask (reg_write_mask),
    .o_reg_read_mask  (reg_read_mask),
    .i_reg_ready      (reg_ready),
    .i_reg_error      (reg_error),
    .i_reg_read_data  (reg_read_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] model_wmask(input logic [NB-1:0] s);
    longint unsigned m = 0;
    for (int k = 0; k < NB; k++) begin
      if (s[k]) m = m + (longint'(255) << (8 * k));
    end
    return BW'(m);
  endfunction

  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] a);
    int unsigned v = a;
    return AW'((v / NB) * NB);
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #1;
    apb_if.psel = 1'b0; apb_if.penable = 1'b0; reg_ready = 1'b0;
    @(negedge clk);
    chk("idle_pready", apb_if.pready, 0);
    chk("idle_valid", reg_valid, 0);
    chk("idle_prdata", apb_if.prdata, exp_prdata);
    chk("idle_pslverr", apb_if.pslverr, exp_pslverr);
  endtask

  // One complete APB transfer; ready arrives after 'delay' busy cycles.
  task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [BW-1:0] wdata,
                      input logic [NB-1:0] strb, input int delay, input logic [BW-1:0] rdata,
                      input bit err, input bit drop);
    bit to_hit;
    int n_busy;
    to_hit = TO_EN && (delay + 1 > TO);
    n_busy = to_hit ? TO : delay + 1;
    @(posedge clk); #1;
    apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = wr;
    apb_if.paddr = addr; apb_if.pwdata = wdata; apb_if.pstrb = strb;
    reg_ready = 1'b0; reg_read_data = rdata; reg_error = err;
    @(negedge clk);
    chk("setup_valid", reg_valid, 0);
    chk("setup_pready", apb_if.pready, 0);
    for (int i = 0; i < n_busy; i++) begin
      @(posedge clk); #1;
      apb_if.penable = 1'b1;
      if (drop && i > 0) begin apb_if.psel = 1'b0; apb_if.penable = 1'b0; end
      apb_if.paddr = AW'($urandom); apb_if.pwdata = $urandom;
      reg_ready = (i == delay);
      @(negedge clk);
      chk("busy_valid", reg_valid, 1);
      chk("busy_pready", apb_if.pready, 0);
      chk("busy_addr", reg_address, model_addr(addr));
      chk("busy_wdata", reg_write_data, wdata);
      chk("busy_wmask", reg_write_mask, wr ? model_wmask(strb) : '0);
      chk("busy_rmask", reg_read_mask, wr ? '0 : {BW{1'b1}});
    end
    @(posedge clk); #1;
    reg_ready = 1'b0; reg_read_data = $urandom; reg_error = 1'($urandom);
    if (to_hit) begin
      exp_prdata = '0; exp_pslverr = 1'b1;
    end else begin
      exp_prdata = wr ? '0 : rdata; exp_pslverr = err;
    end
    @(negedge clk);
    chk("resp_pready", apb_if.pready, 1);
    chk("resp_prdata", apb_if.prdata, exp_prdata);
    chk("resp_pslverr", apb_if.pslverr, exp_pslverr);
    chk("resp_valid", reg_valid, 0);
    chk("resp_masks", {reg_write_mask, reg_read_mask}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
    apb_if.paddr = '0; apb_if.pwdata = '0; apb_if.pstrb = '0;
    reg_ready = 1'b0; reg_error = 1'b0; reg_read_data = '0;
    exp_prdata = '0; exp_pslverr = 1'b0;
    #1;
    chk("rst_valid", reg_valid, 0);
    chk("rst_masks", {reg_write_mask, reg_read_mask}, 0);
    chk("rst_pready", apb_if.pready, 0);
    chk("rst_prdata", apb_if.prdata, 0);
    chk("rst_pslverr", apb_if.pslverr, 0);
    chk("rst_addr", reg_address, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle_cycle();

    // write with byte strobes, zero wait
    xfer(1'b1, 16'h0014, 32'h12345678, 4'b0101, 0, 32'h0, 1'b0, 1'b0);
    idle_cycle();
    // read with four-cycle ready delay
    xfer(1'b0, 16'h0008, 32'h0, 4'hF, 4, 32'hA5A5A5A5, 1'b0, 1'b0);
    idle_cycle();
    // erroring write
    xfer(1'b1, 16'h0020, 32'hDEADBEEF, 4'hF, 1, 32'h5555AAAA, 1'b1, 1'b0);
    idle_cycle();
    // back-to-back read then write, unaligned address
    xfer(1'b0, 16'h0103, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0, 1'b0);
    xfer(1'b1, 16'h0106, 32'h0BADBEEF, 4'b1010, 2, 32'h11111111, 1'b0, 1'b0);
    xfer(1'b0, 16'h0200, 32'h0, 4'h0, 1, 32'h76543210, 1'b0, 1'b0);
    idle_cycle();
    // psel dropped mid-access
    xfer(1'b0, 16'h0044, 32'h0, 4'h0, 3, 32'h13572468, 1'b1, 1'b1);
    idle_cycle();

    // reset in the second busy cycle
    @(posedge clk); #1;
    apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0; apb_if.paddr = 16'h0030;
    reg_ready = 1'b0;
    @(posedge clk); #1;
    apb_if.penable = 1'b1;
    @(negedge clk);
    chk("rb_valid", reg_valid, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_prdata = '0; exp_pslverr = 1'b0;
    chk("rb_valid_drop", reg_valid, 0);
    chk("rb_rmask", reg_read_mask, 0);
    chk("rb_prdata", apb_if.prdata, 0);
    chk("rb_pslverr", apb_if.pslverr, 0);
    apb_if.psel = 1'b0; apb_if.penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rb_no_pready", apb_if.pready, 0);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    idle_cycle();
    xfer(1'b0, 16'h0030, 32'h0, 4'h0, 0, 32'h89ABCDEF, 1'b0, 1'b0);
    idle_cycle();

    // ready withheld: times out with the macro, otherwise waits it out
    xfer(1'b0, 16'h0040, 32'h0, 4'h0, 20, 32'h0BADF00D, 1'b0, 1'b0);
    idle_cycle();
    // ready arriving on the last allowed busy cycle is a normal response
    xfer(1'b0, 16'h0048, 32'h0, 4'h0, TO - 1, 32'h24681357, 1'b0, 1'b0);
    idle_cycle();

    for (int n = 0; n < 40; n++) begin
      xfer(1'($urandom), AW'($urandom), $urandom, NB'($urandom), int'($urandom_range(0, 5)),
           $urandom, 1'($urandom), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
